regfile_2r1w: RTL
=================

REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of each architectural register and of all data ports.
REQ-002 Parameter ADDR_WIDTH, default 5, register index width; register count is 2**ADDR_WIDTH.
REQ-003 clk_i  input  1  clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 we_i  input  1  write enable for the write port.
REQ-006 waddr_i  input  ADDR_WIDTH  write register index.
REQ-007 wdata_i  input  DATA_WIDTH  write data.
REQ-008 re_a_i  input  1  read enable, port A.
REQ-009 raddr_a_i  input  ADDR_WIDTH  read index, port A.
REQ-010 rdata_a_o  output  DATA_WIDTH  registered read data, port A.
REQ-011 re_b_i  input  1  read enable, port B.
REQ-012 raddr_b_i  input  ADDR_WIDTH  read index, port B.
REQ-013 rdata_b_o  output  DATA_WIDTH  registered read data, port B.

Function
REQ-014 Index 0 SHALL be hardwired zero: writes to index 0 are discarded and reads of index 0 return 0.
REQ-015 On a rising edge with we_i=1 and waddr_i!=0, entry waddr_i SHALL take wdata_i; all other entries hold.
REQ-016 Reads SHALL be synchronous with 1-cycle latency: at a rising edge with re_x_i=1, rdata_x_o takes the value of entry raddr_x_i.
REQ-017 With re_x_i=0 at a rising edge, rdata_x_o SHALL hold its previous value, regardless of writes to the previously read entry.
REQ-018 Write-read collision: with we_i=1, re_x_i=1, raddr_x_i==waddr_i!=0 at the same edge, rdata_x_o SHALL take wdata_i (write-first bypass).
REQ-019 Collision on index 0 (we_i=1, waddr_i=0, raddr_x_i=0) SHALL return 0 on rdata_x_o.
REQ-020 Ports A and B SHALL be fully independent; both may read the same index, including the index being written, in the same cycle.
REQ-021 Addresses are always in range (full 2**ADDR_WIDTH decode); no error signalling.
REQ-022 Outputs SHALL depend only on state; no combinational path from any input to rdata_a_o or rdata_b_o.

Reset
REQ-023 While rst_i=1, all entries and rdata_a_o, rdata_b_o SHALL be 0, independent of clk_i.
REQ-024 Writes and reads presented during reset SHALL have no effect.
REQ-025 After rst_i deasserts, the first rising edge SHALL perform normal write/read operation.
REQ-026 Reset asserted mid-operation SHALL discard any write on the same edge; no partial state survives.

Structure
REQ-027 DATA_WIDTH, ADDR_WIDTH defaults and the zero-register index constant SHALL live in the shared riscv_pkg package.
REQ-028 Each read output register SHALL be an instance of the existing register sub-module (ce_i driven by the port read enable, d_i by the bypass mux).
REQ-029 Storage array entries 1..2**ADDR_WIDTH-1 SHALL be a single clocked array with asynchronous clear; entry 0 SHALL not be implemented as storage.

Verification
REQ-030 Reset: rst_i=1 then release; read all 32 indices on both ports -> every rdata = 0x00000000.
REQ-031 Write x5=0xDEADBEEF, next cycle re_a_i=1 raddr_a_i=5 -> rdata_a_o=0xDEADBEEF one cycle later; rdata_b_o unchanged.
REQ-032 Write x0=0xFFFFFFFF, then read x0 on A and B -> both 0x00000000; same-cycle collision on x0 -> 0x00000000.
REQ-033 Same edge: we_i=1 waddr_i=7 wdata_i=0x12345678, re_a_i=re_b_i=1 both raddr=7 (x7 previously 0x1) -> both outputs 0x12345678.
REQ-034 Read x3 (0xA5A5A5A5), then re_a_i=0 while writing x3=0x0 -> rdata_a_o stays 0xA5A5A5A5 until next enabled read, which returns 0x0.
REQ-035 Assert rst_i asynchronously between edges while x9=0x55 is held on rdata_a_o -> rdata_a_o=0 immediately; post-reset read of x9 -> 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core constants: register file geometry
// and the hardwired-zero register index.
package riscv_pkg;

   localparam int RF_DATA_WIDTH = 32;
   localparam int RF_ADDR_WIDTH = 5;

   // x0 always reads as zero and ignores writes
   localparam int RF_ZERO_IDX = 0;

   // Identifies which read port a value is for
   typedef enum logic {
      RF_PORT_A = 1'b0,
      RF_PORT_B = 1'b1
   } rf_port_e;

   // True when idx names the hardwired-zero register
   function automatic logic rf_is_zero(
      input logic [RF_ADDR_WIDTH-1:0] idx
   );
      return idx == RF_ADDR_WIDTH'(RF_ZERO_IDX);
   endfunction

endpackage

// File: rtl/regfile_2r1w_dff.sv
// Enabled register with asynchronous active-high
// clear. Ports: clk_i, rst_i, ce_i, d_i, q_o.
module regfile_2r1w_dff #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             ce_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         q_o <= '0;
      end else if (ce_i) begin
         q_o <= d_i;
      end
   end

endmodule

// File: rtl/regfile_2r1w.sv
// Two-read one-write register file, x0 hardwired zero,
// registered reads with write-first bypass.
// Ports: clk_i, rst_i (async, active-high);
//   write: we_i, waddr_i, wdata_i;
//   read A: re_a_i, raddr_a_i -> rdata_a_o;
//   read B: re_b_i, raddr_b_i -> rdata_b_o.
module regfile_2r1w
   import riscv_pkg::*;
#(
   parameter int DATA_WIDTH = RF_DATA_WIDTH,
   parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  re_a_i,
   input  logic [ADDR_WIDTH-1:0] raddr_a_i,
   output logic [DATA_WIDTH-1:0] rdata_a_o,
   input  logic                  re_b_i,
   input  logic [ADDR_WIDTH-1:0] raddr_b_i,
   output logic [DATA_WIDTH-1:0] rdata_b_o
);

   localparam int NREG = 2 ** ADDR_WIDTH;

   localparam logic [ADDR_WIDTH-1:0] ZERO_IDX =
      ADDR_WIDTH'(RF_ZERO_IDX);

   // Entry 0 has no storage
   logic [DATA_WIDTH-1:0] mem [1:NREG-1];

   logic                  wr_en;
   logic [DATA_WIDTH-1:0] rd_a_d;
   logic [DATA_WIDTH-1:0] rd_b_d;

   assign wr_en = we_i && (waddr_i != ZERO_IDX);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 1; i < NREG; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         for (int i = 1; i < NREG; i++) begin
            if (waddr_i == ADDR_WIDTH'(i)) begin
               mem[i] <= wdata_i;
            end
         end
      end
   end

   // Read mux, port A. Index 0 falls through to the
   // zero default; a same-edge write to the read
   // index wins over the stored value.
   always_comb begin
      rd_a_d = '0;
      for (int i = 1; i < NREG; i++) begin
         if (raddr_a_i == ADDR_WIDTH'(i)) begin
            rd_a_d = mem[i];
         end
      end
      if (wr_en && (waddr_i == raddr_a_i)) begin
         rd_a_d = wdata_i;
      end
   end

   // Read mux, port B (same structure as A)
   always_comb begin
      rd_b_d = '0;
      for (int i = 1; i < NREG; i++) begin
         if (raddr_b_i == ADDR_WIDTH'(i)) begin
            rd_b_d = mem[i];
         end
      end
      if (wr_en && (waddr_i == raddr_b_i)) begin
         rd_b_d = wdata_i;
      end
   end

   regfile_2r1w_dff #(
      .WIDTH (DATA_WIDTH)
   ) u_rd_a (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .ce_i  (re_a_i),
      .d_i   (rd_a_d),
      .q_o   (rdata_a_o)
   );

   regfile_2r1w_dff #(
      .WIDTH (DATA_WIDTH)
   ) u_rd_b (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .ce_i  (re_b_i),
      .d_i   (rd_b_d),
      .q_o   (rdata_b_o)
   );

endmodule
